// File: rtl/down_counter_ctrl.sv
// down_counter_ctrl
//   Sequencing controller for the down-counter datapath. It loads a start
//   value and counts it down to zero, decrementing once every DIV clocks.
//   Pause freezes the count. Abort returns the block to IDLE.
//   Completion is flagged with a registered one-cycle done pulse.
//
// Optional feature (compile-time macro DOWN_COUNTER_CTRL_AUTO_RELOAD_EN):
//   defined   - the terminal tick reloads the captured start value and the
//               run continues; done pulses once per period.
//   undefined - the terminal tick drives q to 0 and returns to IDLE.
//
// Parameters:
//   WIDTH  count width in bits (>=1)
//   DIV    clocks per decrement (>=1)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      load request, sampled only in IDLE
//   load_val   start count, captured when start is accepted
//   pause      level; holds prescaler and count while RUN
//   abort      synchronous return to IDLE (priority below rst)
//   q          current count
//   q_not      bitwise inverse of q
//   busy       1 while in RUN, including while paused
//   done       one-cycle pulse on terminal count
//   state_dbg  current FSM state (0 = IDLE, 1 = RUN)
//
// Handshake: start is a request level with no ready. It is accepted on any
// rising edge where the state is IDLE and abort is low. busy rising on the
// following cycle, or a done pulse for a zero load, acknowledges it.
module down_counter_ctrl #(
  parameter int WIDTH = 3,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_not,
  output logic             busy,
  output logic             done,
  output logic             state_dbg
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [PW-1:0]    pre;
  logic [WIDTH-1:0] reload;
  logic             tick;

  // With DIV == 1, every un-paused edge is a tick.
  // The prescaler then stays at 0.
  assign tick = (DIV == 1) ? 1'b1 : (pre == PRE_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      q      <= '0;
      pre    <= '0;
      reload <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (abort) begin
            q <= '0;
          end else if (start) begin
            if (load_val != '0) begin
              q      <= load_val;
              reload <= load_val;
              pre    <= '0;
              state  <= RUN;
            end else begin
              // A zero load is a zero-length count.
              // It completes at once without entering RUN.
              q    <= '0;
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            q     <= '0;
            pre   <= '0;
          end else if (!pause) begin
            if (tick) begin
              pre <= '0;
              if (q > WIDTH'(1)) begin
                q <= q - WIDTH'(1);
              end else begin
                done <= 1'b1;
`ifdef DOWN_COUNTER_CTRL_AUTO_RELOAD_EN
                q <= reload;
`else
                q     <= '0;
                state <= IDLE;
`endif
              end
            end else begin
              pre <= pre + PW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          q     <= '0;
          pre   <= '0;
        end
      endcase
    end
  end

  assign q_not     = ~q;
  assign busy      = (state == RUN);
  assign state_dbg = state;

endmodule

// File: tb/tb_down_counter_ctrl.sv
module tb_down_counter_ctrl;
  localparam int W  = 3;
  localparam int EW = 2 * W + 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, pause, abort;
  logic [W-1:0] load_val;

  logic [W-1:0] q_a, qn_a, q_b, qn_b;
  logic         busy_a, done_a, dbg_a, busy_b, done_b, dbg_b;

  down_counter_ctrl #(.WIDTH(W), .DIV(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .load_val(load_val),
    .pause(pause), .abort(abort), .q(q_a), .q_not(qn_a),
    .busy(busy_a), .done(done_a), .state_dbg(dbg_a)
  );

  down_counter_ctrl #(.WIDTH(W), .DIV(3)) dut_b (
    .clk(clk), .rst(rst), .start(start), .load_val(load_val),
    .pause(pause), .abort(abort), .q(q_b), .q_not(qn_b),
    .busy(busy_b), .done(done_b), .state_dbg(dbg_b)
  );

  // scoreboard
  logic [EW-1:0] exp_qa[$];
  logic [EW-1:0] exp_qb[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [EW-1:0] act,
                       input logic [EW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  // Reference model. It counts elapsed run edges per DUT.
  // Index 0 models DIV=1 and index 1 models DIV=3.
  int m_div[2] = '{1, 3};
  bit m_run[2];
  int m_q[2];
  int m_edges[2];
  int m_reload[2];
  bit m_done[2];

  function automatic void model_edge(int i, bit r, bit s, int lv, bit p, bit a);
    if (!r) begin
      m_run[i] = 0; m_q[i] = 0; m_edges[i] = 0; m_reload[i] = 0; m_done[i] = 0;
      return;
    end
    m_done[i] = 0;
    if (!m_run[i]) begin
      if (a) m_q[i] = 0;
      else if (s) begin
        if (lv != 0) begin
          m_q[i] = lv; m_reload[i] = lv; m_edges[i] = 0; m_run[i] = 1;
        end else begin
          m_q[i] = 0; m_done[i] = 1;
        end
      end
    end else if (a) begin
      m_run[i] = 0; m_q[i] = 0; m_edges[i] = 0;
    end else if (!p) begin
      m_edges[i] = m_edges[i] + 1;
      if (m_edges[i] == m_div[i]) begin
        m_edges[i] = 0;
        if (m_q[i] > 1) m_q[i] = m_q[i] - 1;
        else begin
          m_done[i] = 1;
`ifdef DOWN_COUNTER_CTRL_AUTO_RELOAD_EN
          m_q[i] = m_reload[i];
`else
          m_q[i] = 0;
          m_run[i] = 0;
`endif
        end
      end
    end
  endfunction

  function automatic logic [EW-1:0] model_out(int i);
    logic [W-1:0] qv;
    qv = m_q[i][W-1:0];
    return {qv, ~qv, m_run[i], m_done[i]};
  endfunction

  // Driver. Inputs change 1 time unit after the falling edge.
  // The outputs expected after the next rising edge are queued then.
  // An asserted reset takes effect at once and holds through that edge,
  // so the same entry also covers it.
  task automatic drive(input bit r, input bit s, input int lv, input bit p, input bit a);
    @(negedge clk);
    #1;
    rst = r; start = s; load_val = lv[W-1:0]; pause = p; abort = a;
    for (int i = 0; i < 2; i++) model_edge(i, r, s, lv, p, a);
    exp_qa.push_back(model_out(0));
    exp_qb.push_back(model_out(1));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1, 0, 0, 0, 0);
  endtask

  // Monitor. It samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (exp_qa.size() > 0) check("div1_outputs", {q_a, qn_a, busy_a, done_a}, exp_qa.pop_front());
    if (exp_qb.size() > 0) check("div3_outputs", {q_b, qn_b, busy_b, done_b}, exp_qb.pop_front());
  end

  initial begin
    int wait_cnt;
    rst = 0; start = 0; pause = 0; abort = 0; load_val = '0;
    // reset and release
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    idle(2);
    // reset mid-count at q=3 (DIV=1 DUT)
    drive(1, 1, 5, 0, 0);
    idle(2);
    drive(0, 0, 0, 0, 0);
    #1;
    check("async_reset_immediate", {2'b00, q_a, q_b},
          {2'b00, {W{1'b0}}, {W{1'b0}}});
    check("async_reset_no_done", {6'd0, done_a, done_b}, '0);
    drive(1, 0, 0, 0, 0);
    // plain countdown from 5
    drive(1, 1, 5, 0, 0);
    idle(18);
    // load 6, pause 3 cycles once q reads 3
    drive(1, 1, 6, 0, 0);
    idle(3);
    drive(1, 0, 0, 1, 0); drive(1, 0, 0, 1, 0); drive(1, 0, 0, 1, 0);
    idle(20);
    // zero-length count
    drive(1, 1, 0, 0, 0);
    idle(2);
    // abort with start in the same cycle
    drive(1, 1, 7, 0, 0);
    idle(3);
    drive(1, 1, 5, 0, 1);
    idle(2);
    // abort in IDLE
    drive(1, 0, 0, 0, 1);
    // DIV=3 countdown from 2, then a load of 3
    drive(1, 1, 2, 0, 0);
    idle(10);
    drive(1, 1, 3, 0, 0);
    idle(12);
    drive(1, 0, 0, 0, 1);
    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      drive(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 3) == 0),
            int'($urandom_range(0, (1 << W) - 1)),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 24) == 0));
    end
    idle(2);
    // drain the scoreboard within a bounded window
    wait_cnt = 0;
    while ((exp_qa.size() > 0 || exp_qb.size() > 0) && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    n_checks++;
    if (exp_qa.size() == 0 && exp_qb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: pending=%0d required=0",
                  exp_qa.size() + exp_qb.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
